// File: rtl/filter_pkg.sv
// Shared definitions for the filter block: command codes, scheduler state
// encoding and default command width.
package filter_pkg;

  localparam int CMD_WIDTH = 16;

  localparam logic [15:0] CMD_A010       = 16'hA010;
  localparam logic [15:0] CMD_A020       = 16'hA020;
  localparam logic [15:0] CMD_A030       = 16'hA030;
  localparam logic [15:0] CMD_HIST_STATS = 16'hA040;
  localparam logic [15:0] CMD_HIST_EQ    = 16'hA050;
  localparam logic [15:0] CMD_A060       = 16'hA060;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RAM = 2'd1,
    ST_RUN      = 2'd2
  } filter_state_e;

  function automatic logic isValidCmd(input logic [15:0] code);
    return code inside {CMD_A010, CMD_A020, CMD_A030,
                        CMD_HIST_STATS, CMD_HIST_EQ, CMD_A060};
  endfunction

endpackage

// File: rtl/filter_cmd_fifo.sv
// Synchronous show-ahead command queue with full/empty flags and a flush.
// DEPTH must be a power of two; pointers carry one extra wrap bit.
module filter_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_doPush;
  logic             w_doPop;

  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  // A full queue refuses pushes even when a pop frees a slot this cycle.
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_data   = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/filter_cmd_scheduler.sv
// Queues filter commands and issues them one at a time once image RAM is granted,
// inserting a histogram statistics pass ahead of equalization when needed.
// Optional code validation is enabled with the FILTER_CMD_VALIDATE_EN macro.
module filter_cmd_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int CMD_WIDTH  = filter_pkg::CMD_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [CMD_WIDTH-1:0] cmd_data,
  output logic                 cmd_ready,
  input  logic                 abort,
  input  logic                 is_image_RAM_available,
  input  logic                 filter_done,
  output logic [CMD_WIDTH-1:0] command,
  output logic                 stop,
  output logic                 busy,
  output logic                 error,
  output logic [7:0]           cmds_done
);

  import filter_pkg::*;

  filter_state_e        r_state;
  filter_state_e        w_nextState;
  logic [CMD_WIDTH-1:0] r_curCmd;
  logic                 r_histValid;
  logic                 r_autoStats;
  logic [7:0]           r_cmdsDone;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_headValid;
  logic                 w_needStats;
  logic                 w_passDone;
  logic [CMD_WIDTH-1:0] w_head;
  logic [CMD_WIDTH-1:0] w_issued;

  assign cmd_ready   = !w_full && !abort && !rst;
  assign w_push      = cmd_valid && cmd_ready;
  assign w_pop       = (r_state == ST_IDLE) && !w_empty && !abort;
  assign w_needStats = (r_curCmd == CMD_WIDTH'(CMD_HIST_EQ)) && !r_histValid;
  assign w_passDone  = (r_state == ST_RUN) && filter_done && !abort;
  assign w_issued    = r_autoStats ? CMD_WIDTH'(CMD_HIST_STATS) : r_curCmd;
  assign cmds_done   = r_cmdsDone;

`ifdef FILTER_CMD_VALIDATE_EN
  logic r_error;
  assign w_headValid = isValidCmd(16'(w_head));
  assign error       = r_error;

  // Invalid codes are dropped at pop time and latch the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst || abort)
      r_error <= 1'b0;
    else if (w_pop && !w_headValid)
      r_error <= 1'b1;
  end
`else
  assign w_headValid = 1'b1;
  assign error       = 1'b0;
`endif

  filter_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (abort),
    .i_push  (w_push),
    .i_data  (cmd_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (abort) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (!w_empty && w_headValid) w_nextState = ST_WAIT_RAM;
        ST_WAIT_RAM: if (is_image_RAM_available) w_nextState = ST_RUN;
        ST_RUN:      if (filter_done) w_nextState = r_autoStats ? ST_WAIT_RAM : ST_IDLE;
        default:     w_nextState = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    command = '0;
    stop    = 1'b1;
    busy    = (r_state != ST_IDLE) || !w_empty;
    if (r_state == ST_RUN) begin
      command = w_issued;
      stop    = 1'b0;
    end
  end

  // The stats-insertion decision is frozen when the pass starts; an inserted
  // pass finishing leaves the user command pending and uncounted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_curCmd    <= '0;
      r_histValid <= 1'b0;
      r_autoStats <= 1'b0;
      r_cmdsDone  <= 8'd0;
    end else if (abort) begin
      r_autoStats <= 1'b0;
    end else begin
      if (w_pop && w_headValid)
        r_curCmd <= w_head;
      if ((r_state == ST_WAIT_RAM) && is_image_RAM_available)
        r_autoStats <= w_needStats;
      if (w_passDone) begin
        r_histValid <= (w_issued == CMD_WIDTH'(CMD_HIST_STATS));
        if (!r_autoStats)
          r_cmdsDone <= r_cmdsDone + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_filter_cmd_scheduler.sv
// Scoreboard bench for filter_cmd_scheduler: directed scenarios plus a random
// phase, checked against a queue-based model of the scheduling rules.
module tb_filter_cmd_scheduler;

  localparam logic [15:0] C_A010 = 16'hA010;
  localparam logic [15:0] C_A020 = 16'hA020;
  localparam logic [15:0] C_A030 = 16'hA030;
  localparam logic [15:0] C_STAT = 16'hA040;
  localparam logic [15:0] C_EQ   = 16'hA050;
  localparam logic [15:0] C_A060 = 16'hA060;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        abort;
  logic        ramAvail;
  logic        filter_done;
  logic [15:0] command;
  logic        stop;
  logic        busy;
  logic        error;
  logic [7:0]  cmds_done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] modelQ[$];
  logic [15:0] pendCode[$];
  bit          pendUser[$];
  logic [15:0] curCode;
  bit          curUser;
  bit          curActive = 1'b0;
  bit          hv        = 1'b0;
  int          expDone   = 0;
  bit          prevStop  = 1'b1;

  filter_cmd_scheduler #(.FIFO_DEPTH(4), .CMD_WIDTH(16)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .cmd_valid              (cmd_valid),
    .cmd_data               (cmd_data),
    .cmd_ready              (cmd_ready),
    .abort                  (abort),
    .is_image_RAM_available (ramAvail),
    .filter_done            (filter_done),
    .command                (command),
    .stop                   (stop),
    .busy                   (busy),
    .error                  (error),
    .cmds_done              (cmds_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit codeOk(input logic [15:0] c);
`ifdef FILTER_CMD_VALIDATE_EN
    return c inside {C_A010, C_A020, C_A030, C_STAT, C_EQ, C_A060};
`else
    return 1'b1;
`endif
  endfunction

  // Expand the next user command into the passes it should produce.
  function automatic void expandNext();
    logic [15:0] c;
    while (modelQ.size() > 0 && !codeOk(modelQ[0])) void'(modelQ.pop_front());
    if (modelQ.size() == 0) return;
    c = modelQ.pop_front();
    if (c == C_EQ && !hv) begin
      pendCode.push_back(C_STAT); pendUser.push_back(1'b0);
    end
    pendCode.push_back(c); pendUser.push_back(1'b1);
  endfunction

  // Monitor: samples on the falling edge, compares the DUT and advances the model.
  always @(negedge clk) begin
    if (rst) begin
      modelQ.delete(); pendCode.delete(); pendUser.delete();
      curActive = 1'b0; hv = 1'b0; expDone = 0; prevStop = 1'b1;
    end else begin
      checkOutput("cmds_done_track", {24'd0, cmds_done}, expDone);
      if (stop) checkOutput("command_when_stopped", {16'd0, command}, 32'd0);
      if (prevStop && !stop) begin
        if (pendCode.size() == 0) expandNext();
        if (pendCode.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL unexpected_run actual=%h expected=none", command);
        end else begin
          curCode = pendCode.pop_front();
          curUser = pendUser.pop_front();
          curActive = 1'b1;
          checkOutput("issued_code", {16'd0, command}, {16'd0, curCode});
        end
      end
      if (abort) begin
        modelQ.delete(); pendCode.delete(); pendUser.delete();
        curActive = 1'b0;
      end else if (filter_done && !stop && curActive) begin
        hv = (curCode == C_STAT);
        if (curUser) expDone = (expDone + 1) % 256;
        curActive = 1'b0;
      end
      if (cmd_valid && cmd_ready) modelQ.push_back(cmd_data);
      prevStop = stop;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input logic [15:0] c);
    bit accepted = 1'b0;
    cmd_valid = 1'b1; cmd_data = c;
    for (int t = 0; t < 200 && !accepted; t++) begin
      @(negedge clk); accepted = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!accepted) checkOutput("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitRun();
    bit seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      if (!stop) seen = 1'b1;
      else tick();
    end
    if (!seen) checkOutput("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulseDone();
    filter_done = 1'b1; tick(); filter_done = 1'b0;
  endtask

  task automatic drain();
    ramAvail = 1'b1;
    for (int t = 0; t < 600 && busy; t++) begin
      if (!stop) pulseDone();
      else tick();
    end
    checkOutput("drain_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] pool [6];
    pool = '{C_A010, C_A020, C_A030, C_STAT, C_EQ, C_A060};
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; abort = 1'b0;
    ramAvail = 1'b0; filter_done = 1'b0;

    tick(); tick();
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    checkOutput("rst_command", {16'd0, command}, 32'd0);
    checkOutput("rst_stop", {31'd0, stop}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_error", {31'd0, error}, 32'd0);
    checkOutput("rst_cmds_done", {24'd0, cmds_done}, 32'd0);
    rst = 1'b0; tick();

    // Latency from push to RUN with an idle scheduler and RAM granted.
    ramAvail = 1'b1; cmd_valid = 1'b1; cmd_data = C_A030;
    tick(); cmd_valid = 1'b0;
    tick();
    checkOutput("lat_n2_stop", {31'd0, stop}, 32'd1);
    tick();
    checkOutput("lat_n3_stop", {31'd0, stop}, 32'd0);
    checkOutput("lat_n3_command", {16'd0, command}, {16'd0, C_A030});
    pulseDone();
    checkOutput("a030_done_command", {16'd0, command}, 32'd0);
    checkOutput("a030_done_count", {24'd0, cmds_done}, 32'd1);

    // Equalization without valid statistics gets a statistics pass first.
    applyStimulus(C_EQ);
    waitRun();
    checkOutput("eq_first_pass", {16'd0, command}, {16'd0, C_STAT});
    pulseDone();
    checkOutput("eq_stats_not_counted", {24'd0, cmds_done}, 32'd1);
    waitRun();
    checkOutput("eq_second_pass", {16'd0, command}, {16'd0, C_EQ});
    pulseDone();
    checkOutput("eq_done_count", {24'd0, cmds_done}, 32'd2);

    // Fill the queue behind a running command; the fifth push must wait.
    applyStimulus(C_A010); waitRun();
    applyStimulus(C_A020); applyStimulus(C_A030);
    applyStimulus(C_A060); applyStimulus(C_A010);
    cmd_valid = 1'b1; cmd_data = C_A020;
    @(negedge clk);
    checkOutput("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    pulseDone();
    applyStimulus(C_A020);
    drain();

    // RAM withheld: no run until it is granted, then RUN on the next cycle.
    ramAvail = 1'b0;
    applyStimulus(C_A020);
    begin
      int stoppedCycles = 0;
      for (int t = 0; t < 20; t++) begin
        if (stop) stoppedCycles++;
        tick();
      end
      checkOutput("ram_wait_stop", stoppedCycles, 20);
    end
    ramAvail = 1'b1; tick();
    checkOutput("ram_grant_run", {31'd0, stop}, 32'd0);
    pulseDone();

    // Abort while running with three queued commands.
    applyStimulus(C_A010); waitRun();
    applyStimulus(C_A020); applyStimulus(C_A030); applyStimulus(C_A060);
    abort = 1'b1; filter_done = 1'b1; tick(); abort = 1'b0; filter_done = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_stop", {31'd0, stop}, 32'd1);
    checkOutput("abort_command", {16'd0, command}, 32'd0);
    checkOutput("abort_cmds_done", {24'd0, cmds_done}, expDone);

    // Reset while running clears the completion count.
    applyStimulus(C_A030); waitRun();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checkOutput("midrun_rst_count", {24'd0, cmds_done}, 32'd0);
    checkOutput("midrun_rst_busy", {31'd0, busy}, 32'd0);

`ifdef FILTER_CMD_VALIDATE_EN
    applyStimulus(16'h1234);
    applyStimulus(C_A010);
    waitRun();
    checkOutput("invalid_error", {31'd0, error}, 32'd1);
    pulseDone();
    drain();
`endif

    // Random traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cmd_valid = ($urandom_range(99) < 40);
`ifdef FILTER_CMD_VALIDATE_EN
      cmd_data = pool[$urandom_range(5)];
`else
      cmd_data = ($urandom_range(7) == 0) ? 16'($urandom) : pool[$urandom_range(5)];
`endif
      ramAvail    = ($urandom_range(99) < 70);
      filter_done = stop ? ($urandom_range(99) < 3) : ($urandom_range(99) < 25);
      abort       = ($urandom_range(199) == 0);
      tick();
    end
    cmd_valid = 1'b0; abort = 1'b0; filter_done = 1'b0;
    drain();
    tick();
    checkOutput("model_leftover", modelQ.size() + pendCode.size(), 0);
`ifndef FILTER_CMD_VALIDATE_EN
    checkOutput("error_tied_low", {31'd0, error}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
